parity_frame_checker: RTL and testbench
=======================================

Name: parity_frame_checker

Overview:
- Receive end of the even-parity link: accepts a serial frame of WIDTH data bits (LSB first) followed by one parity bit, as produced by the team's parity-generating transmitter.
- Reassembles the word, checks parity over data plus parity bit, and presents the word with an error flag for one cycle.
- Keeps a saturating count of bad frames.
- Sits between the serial link pins and the word-level consumer.

Parameters:
- WIDTH, 16, number of data bits per frame (>=2).
- ODD, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1).
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle pulse; arms reception of a new frame.
- bit_valid  input  1  bit_in is a valid link bit this cycle.
- bit_in  input  1  serial data; data bits LSB first, then the parity bit.
- err_clr  input  1  synchronous clear of err_count.
- busy  output  1  high while a frame is armed (DATA or PAR state).
- out_valid  output  1  one-cycle pulse: data_out and parity_err are valid.
- data_out  output  WIDTH  reassembled word; held until the next frame completes.
- parity_err  output  1  parity mismatch for the frame just completed; held with data_out.
- err_count  output  CNT_W  number of frames completed with error; saturates at all-ones.

Behaviour:
- Reset (async, immediate): state IDLE; busy=0, out_valid=0, data_out=0, parity_err=0, err_count=0; bit counter and running XOR cleared.
- States:
  - IDLE: bit_valid/bit_in ignored. frame_start=1 -> DATA, bit count=0, accumulator=0, running XOR=ODD.
  - DATA: each cycle with bit_valid=1 writes bit_in into position count (LSB first), XORs it into the running parity and increments count. Cycles with bit_valid=0 are stalls and change nothing. The valid bit that makes count==WIDTH moves the block to PAR.
  - PAR: the first cycle with bit_valid=1 supplies the parity bit. On that clock edge:
    - data_out <= accumulator.
    - parity_err <= running XOR ^ bit_in.
    - out_valid <= 1 for exactly one cycle.
    - err_count increments if an error was found.
    - Next state: IDLE, or DATA if frame_start is also high that cycle (back-to-back frames).
- frame_start while in DATA or PAR (not completing): the current frame is aborted and restarted from bit 0. No out_valid, no err_count change, data_out and parity_err unchanged.
- frame_start together with bit_valid in IDLE: only arms the frame; that bit is not captured.
- Latency: out_valid rises on the clock edge that accepts the parity bit, so it is visible in the cycle after the parity bit is presented.
- err_count:
  - Saturates at 2^CNT_W-1.
  - err_clr alone -> 0.
  - err_clr in the same cycle as an error completion -> 1.
- busy = (state != IDLE).
- rst asserted mid-frame: the frame is discarded, no out_valid, all outputs return to reset values.

Decomposition:
- Package parity_pkg:
  - State enum {IDLE, DATA, PAR}.
  - Default WIDTH constant.
  - Helper function for the bit-count width, clog2(WIDTH+1).
- Sub-module sat_err_counter (CNT_W; inc, clr -> count) holds the saturating counter and its clear/increment priority. The frame FSM stays in the top module.

Test Plan:
- Even, clean frame: frame_start, then 16 data bits of 16'h000A LSB first, then parity bit 0 -> one cycle later out_valid=1, data_out=16'h000A, parity_err=0, err_count=0.
- Even, bad frame: 16'h000A with parity bit 1 -> out_valid=1, parity_err=1, err_count=1. Then 16'h0008 with parity bit 1 -> parity_err=0, err_count stays 1.
- Stalls: 16'hFFFF with bit_valid low for 3 cycles between every bit, parity bit 0 -> data_out=16'hFFFF, parity_err=0; busy high from the cycle after frame_start until the parity bit is accepted.
- Abort and back-to-back:
  - frame_start after 7 data bits, then a full frame 16'h1234 with parity 1 -> single out_valid, data_out=16'h1234, parity_err=0.
  - frame_start coincident with that parity bit, then 16'h0001 with parity 1 -> second out_valid with no idle gap, parity_err=0.
- Saturation, clear and reset:
  - 260 bad frames -> err_count=255.
  - err_clr coincident with a further bad frame -> err_count=1.
  - rst pulse mid-frame -> no out_valid, all outputs 0, busy=0.
- ODD=1 instance: 16'h000A with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial parity frame checker.
package parity_pkg;

    // Frame reception states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    // Default number of data bits per frame.
    localparam int DEFAULT_WIDTH = 16;

    // Width of a counter that must hold the values 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // One step of the running parity: fold a new bit into the accumulated XOR.
    function automatic logic par_fold(input logic acc, input logic b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/sat_err_counter.sv
// Saturating error counter. A clear wins over the old value, but an
// increment in the same cycle as a clear still counts, so the result is 1.
module sat_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    import parity_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;

    // Next count: clear/increment priority and saturation at all-ones.
    always_comb begin
        count_s = count_r;
        if (clr) begin
            if (inc) begin
                count_s = CNT_ONE;
            end else begin
                count_s = CNT_ZERO;
            end
        end else if (inc && (count_r != CNT_MAX)) begin
            count_s = count_r + CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/parity_frame_checker.sv
// Receive side of the parity link: reassembles WIDTH data bits (LSB first),
// checks the trailing parity bit and reports the word with an error flag.
module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ODD   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             err_clr,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             parity_err,
    output logic [CNT_W-1:0] err_count
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ACC_ZERO = {WIDTH{1'b0}};
    // Seeding the running XOR with 1 turns an even check into an odd one.
    localparam logic            ODD_BIT  = (ODD != 0) ? 1'b1 : 1'b0;

    state_t           state_r,      state_s;
    logic [CW-1:0]    cnt_r,        cnt_s;
    logic [WIDTH-1:0] acc_r,        acc_s;
    logic             xor_r,        xor_s;
    logic [WIDTH-1:0] data_out_r,   data_out_s;
    logic             parity_err_r, parity_err_s;
    logic             out_valid_r,  out_valid_s;
    logic             inc_s;

    // Next-state and datapath decode for the frame FSM.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        acc_s        = acc_r;
        xor_s        = xor_r;
        data_out_s   = data_out_r;
        parity_err_s = parity_err_r;
        out_valid_s  = 1'b0;
        inc_s        = 1'b0;
        case (state_r)
            IDLE: begin
                // Link bits are ignored here, even alongside frame_start.
                if (frame_start) begin
                    state_s = DATA;
                    cnt_s   = CNT_ZERO;
                    acc_s   = ACC_ZERO;
                    xor_s   = ODD_BIT;
                end else begin
                    state_s = IDLE;
                end
            end
            DATA: begin
                if (frame_start) begin
                    // Abort and restart the frame from bit 0.
                    state_s = DATA;
                    cnt_s   = CNT_ZERO;
                    acc_s   = ACC_ZERO;
                    xor_s   = ODD_BIT;
                end else if (bit_valid) begin
                    acc_s = acc_r | ({{(WIDTH-1){1'b0}}, bit_in} << cnt_r);
                    xor_s = par_fold(xor_r, bit_in);
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_s = PAR;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PAR: begin
                if (bit_valid) begin
                    data_out_s   = acc_r;
                    parity_err_s = par_fold(xor_r, bit_in);
                    out_valid_s  = 1'b1;
                    inc_s        = par_fold(xor_r, bit_in);
                    if (frame_start) begin
                        // Back-to-back: next frame armed on the completing edge.
                        state_s = DATA;
                        cnt_s   = CNT_ZERO;
                        acc_s   = ACC_ZERO;
                        xor_s   = ODD_BIT;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (frame_start) begin
                    state_s = DATA;
                    cnt_s   = CNT_ZERO;
                    acc_s   = ACC_ZERO;
                    xor_s   = ODD_BIT;
                end else begin
                    state_s = PAR;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
                acc_s   = ACC_ZERO;
                xor_s   = ODD_BIT;
            end
        endcase
    end

    // FSM state, datapath and registered output updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_ZERO;
            acc_r        <= ACC_ZERO;
            xor_r        <= 1'b0;
            data_out_r   <= ACC_ZERO;
            parity_err_r <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            acc_r        <= acc_s;
            xor_r        <= xor_s;
            data_out_r   <= data_out_s;
            parity_err_r <= parity_err_s;
            out_valid_r  <= out_valid_s;
        end
    end

    sat_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_s),
        .clr   (err_clr),
        .count (err_count)
    );

    assign busy       = (state_r != IDLE);
    assign out_valid  = out_valid_r;
    assign data_out   = data_out_r;
    assign parity_err = parity_err_r;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed self-checking bench for parity_frame_checker (even and odd instances).
module tb_parity_frame_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        err_clr = 1'b0;

    logic        busy, out_valid, parity_err;
    logic [15:0] data_out;
    logic [7:0]  err_count;

    logic        o_busy, o_out_valid, o_parity_err;
    logic [15:0] o_data_out;
    logic [7:0]  o_err_count;

    int errors = 0;
    int checks = 0;
    int ov_cnt = 0;

    parity_frame_checker #(.WIDTH(16), .ODD(0), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
        .bit_in(bit_in), .err_clr(err_clr), .busy(busy), .out_valid(out_valid),
        .data_out(data_out), .parity_err(parity_err), .err_count(err_count)
    );

    parity_frame_checker #(.WIDTH(16), .ODD(1), .CNT_W(8)) dut_odd (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid),
        .bit_in(bit_in), .err_clr(err_clr), .busy(o_busy), .out_valid(o_out_valid),
        .data_out(o_data_out), .parity_err(o_parity_err), .err_count(o_err_count)
    );

    always #5 clk = ~clk;

    // Count out_valid pulses of the even instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (out_valid === 1'b1) ov_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            bit_valid = 1'b1;
            bit_in    = w[i];
            tick();
        end
        bit_valid = 1'b0;
    endtask

    task automatic send_par(input logic p, input logic fs, input logic clr);
        bit_valid   = 1'b1;
        bit_in      = p;
        frame_start = fs;
        err_clr     = clr;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rst_perr: got %0b want 0", parity_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", err_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean();
        start_frame();
        send_bits(16'h000A);
        send_par(1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_valid: got %0b want 1", out_valid); end
        checks++; if (data_out !== 16'h000A) begin errors++; $display("FAIL clean_data: got %h want 000a", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL clean_perr: got %0b want 0", parity_err); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clean_cnt: got %0d want 0", err_count); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_pulse: got %0b want 0", out_valid); end
        checks++; if (data_out !== 16'h000A) begin errors++; $display("FAIL clean_hold: got %h want 000a", data_out); end
    endtask

    task automatic test_bad();
        start_frame();
        send_bits(16'h000A);
        send_par(1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bad_valid: got %0b want 1", out_valid); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL bad_perr: got %0b want 1", parity_err); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL bad_cnt: got %0d want 1", err_count); end
        start_frame();
        send_bits(16'h0008);
        send_par(1'b1, 1'b0, 1'b0);
        checks++; if (data_out !== 16'h0008) begin errors++; $display("FAIL ok2_data: got %h want 0008", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL ok2_perr: got %0b want 0", parity_err); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL ok2_cnt: got %0d want 1", err_count); end
    endtask

    task automatic test_stall();
        int busy_bad = 0;
        start_frame();
        for (int i = 0; i < 16; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            tick();
            bit_valid = 1'b0;
            bit_in    = 1'b0;
            for (int s = 0; s < 3; s++) begin
                if (busy !== 1'b1) busy_bad++;
                tick();
            end
        end
        checks++; if (busy_bad != 0) begin errors++; $display("FAIL stall_busy: got %0d low cycles want 0", busy_bad); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy_par: got %0b want 1", busy); end
        send_par(1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %0b want 1", out_valid); end
        checks++; if (data_out !== 16'hFFFF) begin errors++; $display("FAIL stall_data: got %h want ffff", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL stall_perr: got %0b want 0", parity_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_idle: got %0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int ov0;
        tick();
        ov0 = ov_cnt;
        start_frame();
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1; tick();
        end
        bit_valid = 1'b0;
        start_frame();
        send_bits(16'h1234);
        send_par(1'b1, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_valid: got %0b want 1", out_valid); end
        checks++; if (data_out !== 16'h1234) begin errors++; $display("FAIL abort_data: got %h want 1234", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL abort_perr: got %0b want 0", parity_err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %0b want 1", busy); end
        send_bits(16'h0001);
        send_par(1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b want 1", out_valid); end
        checks++; if (data_out !== 16'h0001) begin errors++; $display("FAIL b2b_data: got %h want 0001", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL b2b_perr: got %0b want 0", parity_err); end
        tick();
        checks++; if (ov_cnt - ov0 != 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", ov_cnt - ov0); end
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 260; f++) begin
            start_frame();
            send_bits(16'h000A);
            send_par(1'b1, 1'b0, 1'b0);
        end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_cnt: got %0d want 255", err_count); end
        start_frame();
        send_bits(16'h000A);
        send_par(1'b1, 1'b0, 1'b1);
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL clr_inc_cnt: got %0d want 1", err_count); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clr_cnt: got %0d want 0", err_count); end
    endtask

    task automatic test_rst_mid();
        int ov0;
        ov0 = ov_cnt;
        start_frame();
        send_bits(16'h0005);
        bit_valid = 1'b1; bit_in = 1'b1;
        rst = 1'b1;
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rstmid_data: got %h want 0000", data_out); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rstmid_perr: got %0b want 0", parity_err); end
        tick();
        bit_valid = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        checks++; if (ov_cnt != ov0) begin errors++; $display("FAIL rstmid_pulse: got %0d want %0d", ov_cnt, ov0); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", err_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %0b want 0", busy); end
    endtask

    task automatic test_odd();
        start_frame();
        send_bits(16'h000A);
        send_par(1'b1, 1'b0, 1'b0);
        checks++; if (o_out_valid !== 1'b1) begin errors++; $display("FAIL odd_valid: got %0b want 1", o_out_valid); end
        checks++; if (o_parity_err !== 1'b0) begin errors++; $display("FAIL odd_ok_perr: got %0b want 0", o_parity_err); end
        start_frame();
        send_bits(16'h000A);
        send_par(1'b0, 1'b0, 1'b0);
        checks++; if (o_parity_err !== 1'b1) begin errors++; $display("FAIL odd_bad_perr: got %0b want 1", o_parity_err); end
        checks++; if (o_data_out !== 16'h000A) begin errors++; $display("FAIL odd_data: got %h want 000a", o_data_out); end
    endtask

    initial begin
        #1;
        test_reset();
        test_clean();
        test_bad();
        test_stall();
        test_back_to_back();
        test_saturation();
        test_rst_mid();
        test_odd();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
